if_branch_stash: RTL and testbench

IF_BRANCH_STASH -- requirements
Module: if_branch_stash

---
 rtl/if_branch_stash_pkg.sv | 25 ++
 rtl/if_branch_stash_fifo.sv | 57 +++++
 rtl/if_branch_stash.sv | 112 +++++++++++
 tb/tb_if_branch_stash.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/if_branch_stash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_branch_stash_pkg
// Brief    : Shared types and constants for the IF branch stash.
// Revision : 1.0 - initial release
// ============================================================================
package if_branch_stash_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int          c_rec_w  = 65;
  localparam logic [31:0] c_pc_inc = 32'd4;

  // 32-bit pc + 32-bit target + 1-bit prediction = c_rec_w bits
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
  } rec_t;

endpackage
`default_nettype wire

// File: rtl/if_branch_stash_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_branch_stash_fifo
// Brief    : Record FIFO with occupancy count and single-cycle clear.
// Revision : 1.0 - initial release
// ============================================================================
module if_branch_stash_fifo
  import if_branch_stash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic clear_i,
  input  rec_t wdata_i,
  output rec_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [c_rec_w-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]    wptr_q;
  logic [c_aw-1:0]    rptr_q;
  logic [c_cw-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + c_aw'(1);
      if (pop_i)  rptr_q <= rptr_q + c_aw'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + c_cw'(1);
        2'b01:   count_q <= count_q - c_cw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = rec_t'(mem_q[rptr_q]);
  assign full_o  = (count_q == c_cw'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/if_branch_stash.sv
`default_nettype none
// ============================================================================
// Module   : if_branch_stash
// Brief    : In-flight branch stash; feeds predictor updates and mispredict flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_branch_stash
  import if_branch_stash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_target,
  input  logic        push_pred,
  output logic        push_ready,
  input  logic        resolve_valid,
  input  logic        resolve_take,
  output logic        pc_jmp_feedback,
  output logic        pc_jmp_take,
  output logic [31:0] pc_stash_base,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        resolve_err
);

  state_e      state_q, state_d;
  logic        fb_q, fb_d;
  logic        take_q, take_d;
  logic [31:0] base_q, base_d;
  logic        flush_q, flush_d;
  logic [31:0] redir_q, redir_d;
  logic        err_q, err_d;

  rec_t w_head;
  rec_t w_wrec;
  logic w_full, w_empty, w_ready, w_res, w_mis;

  assign w_wrec  = '{pc: push_pc, target: push_target, pred: push_pred};
  assign w_ready = (state_q == ST_RUN) && !w_full;
  assign w_res   = resolve_valid && !w_empty;
  assign w_mis   = w_res && (w_head.pred != resolve_take);

  // A mispredict clears the stash, so a same-cycle push is wrong-path and dropped.
  if_branch_stash_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_valid && w_ready && !w_mis),
    .pop_i   (w_res && !w_mis),
    .clear_i (w_mis),
    .wdata_i (w_wrec),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    state_d = state_q;
    fb_d    = 1'b0;
    take_d  = take_q;
    base_d  = base_q;
    flush_d = 1'b0;
    redir_d = redir_q;
    err_d   = err_q | (resolve_valid & w_empty);
    case (state_q)
      ST_RUN:   if (w_mis) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (w_res) begin
      fb_d   = 1'b1;
      take_d = resolve_take;
      base_d = w_head.pc;
    end
    if (w_mis) begin
      flush_d = 1'b1;
      redir_d = resolve_take ? w_head.target : w_head.pc + c_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fb_q    <= 1'b0;
      take_q  <= 1'b0;
      base_q  <= 32'h0;
      flush_q <= 1'b0;
      redir_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      take_q  <= take_d;
      base_q  <= base_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      err_q   <= err_d;
    end
  end

  assign push_ready      = w_ready;
  assign pc_jmp_feedback = fb_q;
  assign pc_jmp_take     = take_q;
  assign pc_stash_base   = base_q;
  assign flush           = flush_q;
  assign redirect_pc     = redir_q;
  assign resolve_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_branch_stash.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_branch_stash
// Brief    : Directed plus randomized bench against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_branch_stash;
  import if_branch_stash_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [31:0] push_pc;
  logic [31:0] push_target;
  logic        push_pred;
  logic        push_ready;
  logic        resolve_valid;
  logic        resolve_take;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        resolve_err;

  always #5 clk = ~clk;

  if_branch_stash #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .push_valid      (push_valid),
    .push_pc         (push_pc),
    .push_target     (push_target),
    .push_pred       (push_pred),
    .push_ready      (push_ready),
    .resolve_valid   (resolve_valid),
    .resolve_take    (resolve_take),
    .pc_jmp_feedback (pc_jmp_feedback),
    .pc_jmp_take     (pc_jmp_take),
    .pc_stash_base   (pc_stash_base),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .resolve_err     (resolve_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } mrec_t;

  mrec_t       mq[$];
  bit          m_inflush;
  logic        m_fb, m_take, m_fl, m_err;
  logic [31:0] m_base, m_redir;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input logic rst, input logic pv, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pr, input logic rv,
                      input logic rt);
    bit    ready, mis;
    mrec_t h;
    reset = rst; push_valid = pv; push_pc = pc; push_target = tgt;
    push_pred = pr; resolve_valid = rv; resolve_take = rt;
    #1;
    ready = !m_inflush && (mq.size() < DEPTH);
    chk("push_ready", push_ready, ready);
    @(posedge clk);
    #1;
    if (!rst) begin
      mq.delete(); m_inflush = 0;
      m_fb = 0; m_take = 0; m_fl = 0; m_err = 0; m_base = 0; m_redir = 0;
    end else begin
      m_fb = 0; m_fl = 0; mis = 0;
      if (rv && mq.size() == 0) m_err = 1;
      if (rv && mq.size() > 0) begin
        h = mq.pop_front();
        m_fb = 1; m_take = rt; m_base = h.pc;
        if (h.pred != rt) begin
          mis = 1; m_fl = 1;
          m_redir = rt ? h.tgt : h.pc + 32'd4;
          mq.delete();
        end
      end
      if (pv && ready && !mis) mq.push_back('{pc: pc, tgt: tgt, pred: pr});
      m_inflush = mis;
    end
    chk("feedback", pc_jmp_feedback, m_fb);
    chk("take", pc_jmp_take, m_take);
    chk("base", pc_stash_base, m_base);
    chk("flush", flush, m_fl);
    chk("redirect", redirect_pc, m_redir);
    chk("resolve_err", resolve_err, m_err);
    chk("count", dut.u_fifo.count_q, mq.size());
    chk("state_run", dut.state_q == ST_RUN, !m_inflush);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  logic        r_rst, r_pv, r_pr, r_rv, r_rt;
  logic [31:0] r_pc, r_tgt;

  initial begin
    reset = 0; push_valid = 0; push_pc = 0; push_target = 0; push_pred = 0;
    resolve_valid = 0; resolve_take = 0;
    m_inflush = 0; m_fb = 0; m_take = 0; m_fl = 0; m_err = 0; m_base = 0; m_redir = 0;
    @(posedge clk); #1;

    // Reset, then idle
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle();

    // Correct prediction
    step(1, 1, 32'h100, 32'h200, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    idle();

    // Mispredict not-taken, then a push refused during FLUSH
    step(1, 1, 32'h100, 32'h200, 1, 0, 0);
    step(1, 1, 32'h104, 32'h300, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 32'h500, 32'h600, 1, 0, 0);
    idle();

    // Fill, lost 5th push, push+correct resolve while full
    for (int i = 0; i < 4; i++) step(1, 1, 32'h1000 + 4*i, 32'h2000 + 4*i, 1, 0, 0);
    step(1, 1, 32'h1100, 32'h2100, 1, 0, 0);
    step(1, 1, 32'h1200, 32'h2200, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);

    // Resolve on empty stash: sticky error
    step(1, 0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // Push dropped alongside a mispredicting resolve (taken redirect)
    step(1, 1, 32'h700, 32'h7f0, 0, 0, 0);
    step(1, 1, 32'h800, 32'h8f0, 1, 1, 1);
    idle();

    // Pointer wrap, then reset asserted during FLUSH
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'h3000 + 8*i, 32'h4000 + 8*i, i[0], 0, 0);
      step(1, 0, 0, 0, 0, 1, i[0]);
    end
    step(1, 1, 32'h5000, 32'h6000, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 32'h5100, 32'h6100, 1, 1, 1);
    idle();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      r_rst = (($urandom % 80) != 0);
      r_pv  = 1'($urandom % 2);
      r_pc  = $urandom;
      r_tgt = $urandom;
      r_pr  = 1'($urandom % 2);
      r_rv  = (($urandom % 3) == 0);
      if (mq.size() > 0 && ($urandom % 4) != 0) r_rt = mq[0].pred;
      else r_rt = 1'($urandom % 2);
      step(r_rst, r_pv, r_pc, r_tgt, r_pr, r_rv, r_rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
